// File: rtl/decimal_scaler_pkg.sv
// -----------------------------------------------------------------------------
// decimal_scaler_pkg
//   Shared calculator constants and types for the decimal scaler.
//   - CALC_W / CALC_CW : mantissa and step-count widths
//   - MUL10_LIMIT      : largest mantissa that can be multiplied by 10 without
//                        leaving CALC_W bits, floor((2^34-1)/10)
//   - scale_state_t    : controller states
//   - min_cnt()        : smaller of two step counts
// -----------------------------------------------------------------------------
package decimal_scaler_pkg;

    localparam int CALC_W  = 34;
    localparam int CALC_CW = 4;

    localparam logic [CALC_W-1:0] MUL10_LIMIT = 34'd1717986918;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } scale_state_t;

    function automatic logic [CALC_CW-1:0] min_cnt(
        input logic [CALC_CW-1:0] a,
        input logic [CALC_CW-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage : decimal_scaler_pkg

// File: rtl/decimal_scaler_if.sv
// -----------------------------------------------------------------------------
// decimal_scaler_if
//   Request/result bundle between the headroom stage (master) and the
//   decimal scaler (slave).
//   Request  (master -> slave): start, x, req, allowed
//   Result   (slave -> master): busy, done, y, applied, short, ovf
// -----------------------------------------------------------------------------
interface decimal_scaler_if
    import decimal_scaler_pkg::*;
#(
    parameter int W  = CALC_W,
    parameter int CW = CALC_CW
);

    logic          start;
    logic [W-1:0]  x;
    logic [CW-1:0] req;
    logic [CW-1:0] allowed;

    logic          busy;
    logic          done;
    logic [W-1:0]  y;
    logic [CW-1:0] applied;
    logic          short;
    logic          ovf;

    modport master (
        output start, x, req, allowed,
        input  busy, done, y, applied, short, ovf
    );

    modport slave (
        input  start, x, req, allowed,
        output busy, done, y, applied, short, ovf
    );

endinterface : decimal_scaler_if

// File: rtl/decimal_scaler_mul10_step.sv
// -----------------------------------------------------------------------------
// mul10_step
//   One combinational x10 step: acc*10 built as (acc<<3) + (acc<<1), plus a
//   flag telling the controller that this step would not fit in W bits.
//   Ports:
//     i_acc       in  W  current accumulator
//     o_acc_x10   out W  acc*10, truncated to W bits
//     o_would_ovf out 1  acc > LIMIT, the step must be refused
// -----------------------------------------------------------------------------
module mul10_step
    import decimal_scaler_pkg::*;
#(
    parameter int             W     = CALC_W,
    parameter logic [W-1:0]   LIMIT = MUL10_LIMIT
)
(
    input  logic [W-1:0] i_acc,
    output logic [W-1:0] o_acc_x10,
    output logic         o_would_ovf
);

    // The product is only consumed when i_acc <= LIMIT, in which case the
    // carry-out bits above W are always zero, so a W-bit sum loses nothing.
    assign o_acc_x10   = (i_acc << 3) + (i_acc << 1);
    assign o_would_ovf = (i_acc > LIMIT);

endmodule : mul10_step

// File: rtl/decimal_scaler.sv
// -----------------------------------------------------------------------------
// decimal_scaler
//   Sequential x10 scaler. Multiplies a mantissa by 10 once per clock until
//   min(req, allowed) steps are done or the next step would overflow.
//   Ports:
//     clk  in  1      clock
//     rst  in  1      synchronous, active-high reset
//     bus  slave      request/result bundle (see decimal_scaler_if)
//   Timing: start sampled at edge 0, steps on RUN edges 1..s, termination
//   evaluated on edge s+1, done high in the following cycle. tgt = 0 goes
//   straight to DONE at edge 0.
// -----------------------------------------------------------------------------
module decimal_scaler
    import decimal_scaler_pkg::*;
#(
    parameter int W  = CALC_W,
    parameter int CW = CALC_CW
)
(
    input  logic            clk,
    input  logic            rst,
    decimal_scaler_if.slave bus
);

    // Controller
    scale_state_t  r_state;
    scale_state_t  w_next_state;
    logic          w_busy;
    logic          w_done;

    // Operation datapath
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_tgt;
    logic [CW-1:0] r_req;

    // Result registers
    logic [W-1:0]  r_y;
    logic [CW-1:0] r_applied;
    logic          r_short;
    logic          r_ovf;

    logic [W-1:0]  w_acc_x10;
    logic          w_would_ovf;
    logic [CW-1:0] w_tgt_in;
    logic          w_accept;
    logic          w_cnt_hit;
    logic          w_finish;

    mul10_step #(
        .W     (W),
        .LIMIT (MUL10_LIMIT)
    ) u_mul10_step (
        .i_acc       (r_acc),
        .o_acc_x10   (w_acc_x10),
        .o_would_ovf (w_would_ovf)
    );

    assign w_tgt_in  = min_cnt(bus.req, bus.allowed);
    // start is only honoured outside RUN; there is no request queue.
    assign w_accept  = bus.start && (r_state != S_RUN);
    assign w_cnt_hit = (r_cnt == r_tgt);
    // Target reached has priority over the overflow check, so a finished
    // operation never reports a refused step.
    assign w_finish  = w_cnt_hit || w_would_ovf;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on any path that does not assign explicitly.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_next_state = (w_tgt_in == '0) ? S_DONE : S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_finish) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Controller outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath and result registers
    // ---------------------------------------------------------------------
    // NOTE: these are ordinary flops, not a memory array, so they are all
    // reset; the result outputs must read zero right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_tgt     <= '0;
            r_req     <= '0;
            r_y       <= '0;
            r_applied <= '0;
            r_short   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_acc <= bus.x;
            r_cnt <= '0;
            r_tgt <= w_tgt_in;
            r_req <= bus.req;
            // A zero-step request enters DONE immediately, so the result
            // registers are written here instead of from RUN.
            if (w_tgt_in == '0) begin
                r_y       <= bus.x;
                r_applied <= '0;
                r_short   <= (bus.req != '0);
                r_ovf     <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            if (w_finish) begin
                r_y       <= r_acc;
                r_applied <= r_cnt;
                r_short   <= (r_cnt < r_req);
                r_ovf     <= !w_cnt_hit;
            end else begin
                r_acc <= w_acc_x10;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.y       = r_y;
    assign bus.applied = r_applied;
    assign bus.short   = r_short;
    assign bus.ovf     = r_ovf;

endmodule : decimal_scaler

// File: tb/tb_decimal_scaler.sv
// -----------------------------------------------------------------------------
// tb_decimal_scaler
//   Directed bench for decimal_scaler. Expected results are pushed to a
//   scoreboard queue when a request is driven and popped when done rises.
// -----------------------------------------------------------------------------
module tb_decimal_scaler;

    typedef struct {
        logic [33:0] y;
        logic [3:0]  applied;
        logic        short_f;
        logic        ovf;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;

    decimal_scaler_if bus ();

    decimal_scaler #(
        .W  (34),
        .CW (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] last_y;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Called at a falling edge; the request is sampled at the next rising edge.
    task automatic start_op(input logic [33:0] x, input logic [3:0] req,
                            input logic [3:0] allowed, input logic [33:0] ey,
                            input logic [3:0] ea, input logic es,
                            input logic eo, input int lat);
        exp_t e;
        e.y = ey; e.applied = ea; e.short_f = es; e.ovf = eo; e.lat = lat;
        sb.push_back(e);
        bus.start   = 1'b1;
        bus.x       = x;
        bus.req     = req;
        bus.allowed = allowed;
    endtask

    // Waits for done (bounded), optionally pulsing start in RUN at cycle
    // pulse_at, then checks latency, busy behaviour and the popped result.
    // Returns at the falling edge of the done cycle.
    task automatic finish_op(input string tag, input int pulse_at);
        exp_t e;
        int   n;
        logic saw_busy;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        saw_busy = 1'b0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) saw_busy = 1'b1;
            @(negedge clk);
            n++;
            bus.start = (n == pulse_at);
            if (n == pulse_at) begin
                bus.x       = 34'd999;
                bus.req     = 4'd1;
                bus.allowed = 4'd1;
            end
        end
        check({tag, ".done_seen"}, {63'd0, bus.done}, 64'd1);
        check({tag, ".sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".latency"},   n,                 e.lat);
            check({tag, ".busy_run"},  {63'd0, saw_busy}, {63'd0, e.lat > 1});
            check({tag, ".busy_done"}, {63'd0, bus.busy}, 64'd0);
            check({tag, ".y"},         bus.y,             e.y);
            check({tag, ".applied"},   bus.applied,       e.applied);
            check({tag, ".short"},     {63'd0, bus.short}, {63'd0, e.short_f});
            check({tag, ".ovf"},       {63'd0, bus.ovf},  {63'd0, e.ovf});
            last_y = e.y;
        end
    endtask

    // One cycle after done: pulse must be gone, results held.
    task automatic check_hold(input string tag);
        @(negedge clk);
        check({tag, ".done_pulse"}, {63'd0, bus.done}, 64'd0);
        check({tag, ".y_hold"},     bus.y,             last_y);
    endtask

    initial begin
        int done_cnt;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.x       = '0;
        bus.req     = '0;
        bus.allowed = '0;
        last_y      = '0;

        repeat (3) @(negedge clk);
        check("reset.busy",    {63'd0, bus.busy},  64'd0);
        check("reset.done",    {63'd0, bus.done},  64'd0);
        check("reset.y",       bus.y,              64'd0);
        check("reset.applied", bus.applied,        64'd0);
        check("reset.short",   {63'd0, bus.short}, 64'd0);
        check("reset.ovf",     {63'd0, bus.ovf},   64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic three-step scale.
        start_op(34'd123, 4'd3, 4'd9, 34'd123000, 4'd3, 1'b0, 1'b0, 5);
        finish_op("x123", 0);
        check_hold("x123");

        // Zero steps requested.
        start_op(34'd5, 4'd0, 4'd9, 34'd5, 4'd0, 1'b0, 1'b0, 1);
        finish_op("req0", 0);
        check_hold("req0");

        // Headroom limits the step count.
        start_op(34'd42, 4'd7, 4'd3, 34'd42000, 4'd3, 1'b1, 1'b0, 5);
        finish_op("clip", 0);
        check_hold("clip");

        // Exactly at LIMIT: first step fits, second is refused.
        start_op(34'd1717986918, 4'd2, 4'd5, 34'd17179869180, 4'd1, 1'b1, 1'b1, 3);
        finish_op("ovf", 0);
        check_hold("ovf");

        // No headroom at all.
        start_op(34'd9, 4'd5, 4'd0, 34'd9, 4'd0, 1'b1, 1'b0, 1);
        finish_op("allow0", 0);
        check_hold("allow0");

        // Zero mantissa, worst-case step count.
        start_op(34'd0, 4'd15, 4'd15, 34'd0, 4'd15, 1'b0, 1'b0, 17);
        finish_op("x0_max", 0);
        check_hold("x0_max");

        // start pulsed during RUN must be ignored.
        start_op(34'd123, 4'd3, 4'd9, 34'd123000, 4'd3, 1'b0, 1'b0, 5);
        finish_op("ignore", 2);
        check_hold("ignore");

        // Back-to-back: second start issued in the done cycle.
        start_op(34'd42, 4'd7, 4'd3, 34'd42000, 4'd3, 1'b1, 1'b0, 5);
        finish_op("b2b_a", 0);
        start_op(34'd7, 4'd1, 4'd4, 34'd70, 4'd1, 1'b0, 1'b0, 3);
        finish_op("b2b_b", 0);
        check_hold("b2b_b");

        // Reset at RUN edge 2 aborts and clears outputs.
        bus.start   = 1'b1;
        bus.x       = 34'd123;
        bus.req     = 4'd3;
        bus.allowed = 4'd9;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort.busy",    {63'd0, bus.busy},  64'd0);
        check("abort.done",    {63'd0, bus.done},  64'd0);
        check("abort.y",       bus.y,              64'd0);
        check("abort.applied", bus.applied,        64'd0);
        check("abort.short",   {63'd0, bus.short}, 64'd0);
        check("abort.ovf",     {63'd0, bus.ovf},   64'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check("abort.no_done", done_cnt, 64'd0);
        check("sb.drained",    sb.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decimal_scaler
